instmem_responder: RTL and testbench

Instruction-memory responder for the SM core: the serving end of the instruction fetch interface driven by the scheduler's PC. It holds the kernel program, accepts a sequential program load from the host, then answers fetch requests with a registered 32-bit instruction one cycle later. It sits between the host/loader and the scheduler inside each SM core.

---
 rtl/instmem_responder_pkg.sv | 15 +
 rtl/instmem_array.sv | 31 +++
 rtl/instmem_responder.sv | 141 ++++++++++++++
 tb/tb_instmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instmem_responder_pkg.sv
// rtl/instmem_responder_pkg.sv - shared widths, FSM state encodings and NOP word for the instruction-memory responder
package instmem_responder_pkg;

  localparam int INST_LENGTH        = 32;
  localparam int INSTMEM_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IMR_EMPTY = 2'd0,
    IMR_LOAD  = 2'd1,
    IMR_SERVE = 2'd2
  } imr_state_t;

  localparam logic [INST_LENGTH-1:0] INST_NOP = '0;

endpackage

// File: rtl/instmem_array.sv
// rtl/instmem_array.sv - single-write/single-read synchronous RAM holding the kernel program
module instmem_array #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Program storage; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its word between reads, cleared so outputs start at 0
  always_ff @(posedge clk) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instmem_responder.sv
// rtl/instmem_responder.sv - program loader and 1-cycle fetch responder; optional INSTMEM_PARITY_EN adds per-word parity
module instmem_responder
  import instmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = INSTMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = INST_LENGTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  fetch_oob,
  output logic                  parity_err
);

`ifdef INSTMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ARRAY_W = DATA_WIDTH + PAR_W;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  imr_state_t            state;
  logic [ADDR_WIDTH-1:0] wptr;
  logic                  wr_en;
  logic                  last_write;
  logic                  fetch_fire;
  logic                  addr_oob;
  logic [ARRAY_W-1:0]    wr_word;
  logic [ARRAY_W-1:0]    rd_word;

  // load_start wins over a same-cycle word, so that word is never written
  assign wr_en      = (state == IMR_LOAD) && load_valid && !load_start;
  assign last_write = load_last || (wptr == PTR_LAST);
  assign fetch_fire = fetch_ready && fetch_req;
  assign addr_oob   = ({1'b0, fetch_addr} >= prog_len);

`ifdef INSTMEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  instmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (ARRAY_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (wr_word),
    .rd_en   (fetch_fire),
    .rd_addr (fetch_addr),
    .rd_data (rd_word)
  );

  // Load/serve FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IMR_EMPTY;
      wptr        <= '0;
      prog_len    <= '0;
      load_ready  <= 1'b0;
      fetch_ready <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IMR_EMPTY: begin
          if (load_start) begin
            state      <= IMR_LOAD;
            wptr       <= '0;
            load_ready <= 1'b1;
          end
        end
        IMR_LOAD: begin
          if (load_start) begin
            wptr <= '0;
          end else if (load_valid) begin
            if (last_write) begin
              state       <= IMR_SERVE;
              prog_len    <= {1'b0, wptr} + LEN_ONE;
              load_done   <= 1'b1;
              load_ready  <= 1'b0;
              fetch_ready <= 1'b1;
            end else begin
              wptr <= wptr + PTR_ONE;
            end
          end
        end
        IMR_SERVE: begin
          if (load_start) begin
            state       <= IMR_LOAD;
            wptr        <= '0;
            load_ready  <= 1'b1;
            fetch_ready <= 1'b0;
          end
        end
        default: begin
          state       <= IMR_EMPTY;
          load_ready  <= 1'b0;
          fetch_ready <= 1'b0;
        end
      endcase
    end
  end

  // Response qualifiers travel alongside the RAM read; oob holds with the data
  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_valid <= 1'b0;
      fetch_oob  <= 1'b0;
    end else begin
      inst_valid <= fetch_fire;
      if (fetch_fire) fetch_oob <= addr_oob;
    end
  end

  assign inst = fetch_oob ? DATA_WIDTH'(INST_NOP) : rd_word[DATA_WIDTH-1:0];

`ifdef INSTMEM_PARITY_EN
  assign parity_err = !fetch_oob && (^rd_word);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instmem_responder.sv
// tb/tb_instmem_responder.sv - randomized scoreboard bench for instmem_responder
module tb_instmem_responder;
  import instmem_responder_pkg::*;

  localparam int AW    = INSTMEM_ADDR_WIDTH;
  localparam int DW    = INST_LENGTH;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, load_valid, load_last;
  logic [DW-1:0] load_data;
  logic          load_ready, load_done;
  logic [AW:0]   prog_len;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready, inst_valid, fetch_oob, parity_err;
  logic [DW-1:0] inst;

  instmem_responder dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .prog_len(prog_len), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .inst_valid(inst_valid), .inst(inst),
    .fetch_oob(fetch_oob), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    logic          oob;
  } resp_t;

  resp_t         exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] words [DEPTH];
  int            plen    = 0;
  bit            serving = 0;
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Request one fetch in the current cycle; expectation comes from the program model
  task automatic do_fetch(input int a);
    resp_t r;
    fetch_req  = 1'b1;
    fetch_addr = AW'(a);
    if (serving) begin
      r.oob  = (a >= plen);
      r.word = r.oob ? '0 : model_mem[a];
      exp_q.push_back(r);
    end
    cyc();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    serving    = 0;
  endtask

  task automatic load_words(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      while (gaps && ($urandom % 3 == 0)) begin
        load_valid = 1'b0;
        cyc();
        chk("gap_no_done", load_done, 0);
      end
      chk("load_ready_in_load", load_ready, 1);
      load_valid   = 1'b1;
      load_data    = words[i];
      load_last    = use_last && (i == n - 1);
      model_mem[i] = words[i];
      cyc();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("load_done_pulse", load_done, 1);
    chk("prog_len", prog_len, 64'(n));
    chk("fetch_ready_after_load", fetch_ready, 1);
    chk("load_ready_after_load", load_ready, 0);
    plen    = n;
    serving = 1;
  endtask

  task automatic random_fetches(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom % 4 != 0) do_fetch(int'($urandom % DEPTH));
      else begin
        fetch_req = 1'b0;
        cyc();
      end
    end
    fetch_req = 1'b0;
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=inst_valid=1 expected=no response at %0t", $time);
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        chk("resp_inst", inst, r.word);
        chk("resp_oob", fetch_oob, r.oob);
        chk("resp_parity_err", parity_err, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ul;
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
    repeat (2) cyc();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_load_done", load_done, 0);
    reset = 1'b1;

    // Idle in EMPTY: fetches must be ignored
    for (int i = 0; i < 5; i++) begin
      do_fetch(int'($urandom % DEPTH));
      chk("idle_fetch_ready", fetch_ready, 0);
      chk("idle_load_ready", load_ready, 0);
      chk("idle_inst_valid", inst_valid, 0);
      chk("idle_prog_len", prog_len, 0);
    end
    fetch_req = 1'b0;
    cyc();

    // Directed 4-word program
    for (int i = 0; i < 4; i++) words[i] = 32'h1000_0001 + 32'(i);
    start_load();
    load_words(4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      do_fetch(i);
      chk("b2b_valid", inst_valid, 1);
    end
    fetch_req = 1'b0;
    cyc();
    chk("load_done_single", load_done, 0);
    do_fetch(7);
    fetch_req = 1'b0;
    cyc();

    // Fill every word without load_last
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    start_load();
    load_words(DEPTH, 0, 1);
    do_fetch(DEPTH - 1);
    random_fetches(30);
    cyc();

    // load_start alongside a fetch: old word 2 still returned
    fetch_req  = 1'b1;
    fetch_addr = AW'(2);
    load_start = 1'b1;
    begin
      resp_t r;
      r.word = model_mem[2];
      r.oob  = 1'b0;
      exp_q.push_back(r);
    end
    cyc();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    serving    = 0;
    chk("restart_fetch_ready", fetch_ready, 0);
    chk("restart_load_ready", load_ready, 1);
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    load_words(4, 1, 1);
    do_fetch(2);
    fetch_req = 1'b0;
    cyc();

    // Restart inside LOAD drops the same-cycle word
    start_load();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      cyc();
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    cyc();
    load_start = 1'b0;
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    load_words(3, 1, 0);
    for (int i = 0; i < 5; i++) do_fetch(i);
    fetch_req = 1'b0;
    cyc();

    // Random reload rounds
    for (int r = 0; r < 6; r++) begin
      n  = 1 + int'($urandom % DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom % 2);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      start_load();
      load_words(n, ul, 1);
      random_fetches(40);
    end
    cyc();

    // Reset with a fetch in the same cycle: no response
    fetch_req  = 1'b1;
    fetch_addr = '0;
    reset      = 1'b0;
    cyc();
    fetch_req = 1'b0;
    reset     = 1'b1;
    serving   = 0;
    plen      = 0;
    chk("mid_fetch_rst_valid", inst_valid, 0);
    chk("mid_fetch_rst_fetch_ready", fetch_ready, 0);

    // Reset in the middle of a load
    start_load();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      cyc();
    end
    load_valid = 1'b0;
    reset      = 1'b0;
    cyc();
    reset = 1'b1;
    chk("mid_load_rst_prog_len", prog_len, 0);
    chk("mid_load_rst_load_ready", load_ready, 0);
    chk("mid_load_rst_fetch_ready", fetch_ready, 0);
    for (int i = 0; i < 3; i++) do_fetch(i);
    fetch_req = 1'b0;
    repeat (3) cyc();

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
